// File: rtl/uart_rx.sv
// uart_rx: 8-bit asynchronous serial receiver (start, 8 data LSB-first, parity, stop).
// rx_in is oversampled by clk; every bit is sampled at the middle of its period.
module uart_rx #(
  parameter int CLK_FREQUENCY = 100_000_000,
  parameter int BAUD_RATE     = 19_200,
  parameter int PARITY        = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_in,
  output logic [7:0] dout,
  output logic       data_strobe,
  output logic       parity_error,
  output logic       framing_error,
  output logic       busy
);

  localparam int BIT  = CLK_FREQUENCY / BAUD_RATE;
  localparam int HALF = BIT / 2;
  localparam int TW   = $clog2(BIT + 1);
  // The timer restarts at 0, so the N-th cycle of an interval sees timer == N-1.
  localparam logic [TW-1:0] BIT_LAST  = TW'(BIT - 1);
  localparam logic [TW-1:0] HALF_LAST = TW'(HALF - 1);

  typedef enum logic [2:0] {
    WAIT_IDLE = 3'd0,
    IDLE      = 3'd1,
    START     = 3'd2,
    DATA      = 3'd3,
    PAR       = 3'd4,
    STOP      = 3'd5
  } state_t;

  state_t        state, stateNext;
  logic          rxMeta, rxS;
  logic [TW-1:0] timer, timerNext;
  logic [2:0]    bitCnt, bitCntNext;
  logic [7:0]    shiftReg, shiftNext;
  logic          mismatch, mismatchNext;
  logic          frameDone;
  logic          expectedParity;

  assign expectedParity = (PARITY != 0) ? ~^shiftReg : ^shiftReg;

  // The strobe cycle is already back in IDLE/WAIT_IDLE but still counts as busy.
  assign busy = (state == START) || (state == DATA) || (state == PAR) ||
                (state == STOP) || data_strobe;

  always_comb begin
    // NOTE: every signal gets a default first so no path can infer a latch.
    stateNext    = state;
    timerNext    = timer + TW'(1);
    bitCntNext   = bitCnt;
    shiftNext    = shiftReg;
    mismatchNext = mismatch;
    frameDone    = 1'b0;
    unique case (state)
      WAIT_IDLE: begin
        if (!rxS) begin
          timerNext = '0;
        end else if (timer == BIT_LAST) begin
          stateNext = IDLE;
          timerNext = '0;
        end
      end
      IDLE: begin
        timerNext = '0;
        if (!rxS) stateNext = START;
      end
      START: begin
        if (timer == HALF_LAST) begin
          timerNext  = '0;
          bitCntNext = '0;
          stateNext  = rxS ? IDLE : DATA;
        end
      end
      DATA: begin
        if (timer == BIT_LAST) begin
          timerNext         = '0;
          shiftNext[bitCnt] = rxS;
          bitCntNext        = bitCnt + 3'd1;
          if (bitCnt == 3'd7) stateNext = PAR;
        end
      end
      PAR: begin
        if (timer == BIT_LAST) begin
          timerNext    = '0;
          mismatchNext = (rxS != expectedParity);
          stateNext    = STOP;
        end
      end
      STOP: begin
        if (timer == BIT_LAST) begin
          timerNext = '0;
          frameDone = 1'b1;
          stateNext = rxS ? IDLE : WAIT_IDLE;
        end
      end
      default: begin
        stateNext = WAIT_IDLE;
        timerNext = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      // Synchronizer resets to the idle level so reset never looks like a start bit.
      rxMeta        <= 1'b1;
      rxS           <= 1'b1;
      state         <= WAIT_IDLE;
      timer         <= '0;
      bitCnt        <= '0;
      shiftReg      <= '0;
      mismatch      <= 1'b0;
      dout          <= '0;
      data_strobe   <= 1'b0;
      parity_error  <= 1'b0;
      framing_error <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      rxMeta      <= rx_in;
      rxS         <= rxMeta;
      state       <= stateNext;
      timer       <= timerNext;
      bitCnt      <= bitCntNext;
      shiftReg    <= shiftNext;
      mismatch    <= mismatchNext;
      data_strobe <= frameDone;
      if (frameDone) begin
        dout          <= shiftReg;
        parity_error  <= mismatch;
        framing_error <= !rxS;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: odd- and even-parity receivers share one serial line; a queue
// scoreboard per receiver checks every strobe against a bit-counting model.
module tb_uart_rx;

  localparam int CLK_FREQUENCY = 3200;
  localparam int BAUD_RATE     = 100;
  localparam int BIT           = CLK_FREQUENCY / BAUD_RATE;
  localparam int HALF          = BIT / 2;

  typedef struct packed {
    logic [7:0] data;
    logic       parErr;
    logic       frameErr;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rxLine = 1'b1;
  logic [7:0] doutOdd, doutEven;
  logic       strobeOdd, strobeEven;
  logic       parErrOdd, parErrEven;
  logic       frameErrOdd, frameErrEven;
  logic       busyOdd, busyEven;

  exp_t qOdd[$];
  exp_t qEven[$];
  exp_t eOdd, eEven;
  int   testCount = 0;
  int   failCount = 0;

  always #5 clk = ~clk;

  uart_rx #(.CLK_FREQUENCY(CLK_FREQUENCY), .BAUD_RATE(BAUD_RATE), .PARITY(1)) dutOdd (
    .clk(clk), .rst(rst), .rx_in(rxLine), .dout(doutOdd), .data_strobe(strobeOdd),
    .parity_error(parErrOdd), .framing_error(frameErrOdd), .busy(busyOdd)
  );

  uart_rx #(.CLK_FREQUENCY(CLK_FREQUENCY), .BAUD_RATE(BAUD_RATE), .PARITY(0)) dutEven (
    .clk(clk), .rst(rst), .rx_in(rxLine), .dout(doutEven), .data_strobe(strobeEven),
    .parity_error(parErrEven), .framing_error(frameErrEven), .busy(busyEven)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    testCount++;
    if (act !== exp) begin
      failCount++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Model: odd parity means data ones plus parity bit is odd; even means it is even.
  task automatic push_expect(input logic [7:0] d, input logic p, input logic s);
    int ones;
    exp_t e;
    ones       = $countones(d) + int'(p);
    e.data     = d;
    e.frameErr = !s;
    e.parErr   = (ones % 2) != 1;
    qOdd.push_back(e);
    e.parErr   = (ones % 2) != 0;
    qEven.push_back(e);
  endtask

  task automatic drive_bit(input logic b, input int period);
    rxLine = b;
    repeat (period) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic p, input logic s, input int period);
    push_expect(d, p, s);
    drive_bit(1'b0, period);
    for (int i = 0; i < 8; i++) drive_bit(d[i], period);
    drive_bit(p, period);
    drive_bit(s, period);
  endtask

  task automatic wait_drain(input int budget);
    for (int i = 0; i < budget && (qOdd.size() != 0 || qEven.size() != 0); i++)
      @(negedge clk);
    check("drain_pending", qOdd.size() + qEven.size(), 0);
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_dout_odd"}, doutOdd, 0);
    check({tag, "_dout_even"}, doutEven, 0);
    check({tag, "_flags_odd"}, {strobeOdd, parErrOdd, frameErrOdd, busyOdd}, 0);
    check({tag, "_flags_even"}, {strobeEven, parErrEven, frameErrEven, busyEven}, 0);
  endtask

  always @(negedge clk) begin
    if (strobeOdd === 1'b1) begin
      if (qOdd.size() == 0) begin
        check("odd_unexpected_strobe", 1, 0);
      end else begin
        eOdd = qOdd.pop_front();
        check("odd_frame", {busyOdd, frameErrOdd, parErrOdd, doutOdd},
              {1'b1, eOdd.frameErr, eOdd.parErr, eOdd.data});
      end
    end
  end

  always @(negedge clk) begin
    if (strobeEven === 1'b1) begin
      if (qEven.size() == 0) begin
        check("even_unexpected_strobe", 1, 0);
      end else begin
        eEven = qEven.pop_front();
        check("even_frame", {busyEven, frameErrEven, parErrEven, doutEven},
              {1'b1, eEven.frameErr, eEven.parErr, eEven.data});
      end
    end
  end

  initial begin
    #800_000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", testCount, failCount);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] burst [4];
    logic [7:0] partial;
    logic [7:0] d;
    logic       p;

    repeat (3) @(negedge clk);
    check_cleared("reset");
    rst = 1'b0;
    repeat (BIT + 4) @(negedge clk);

    // Back-to-back frames with correct odd parity.
    burst = '{8'h00, 8'hFF, 8'hA5, 8'h5A};
    foreach (burst[i]) send_frame(burst[i], ~^burst[i], 1'b1, BIT);
    wait_drain(4 * BIT);

    // Short low glitch must be rejected without a strobe.
    rxLine = 1'b0;
    repeat (6) @(negedge clk);
    check("glitch_busy_odd", busyOdd, 1);
    check("glitch_busy_even", busyEven, 1);
    repeat (BIT / 4 - 6) @(negedge clk);
    rxLine = 1'b1;
    repeat (HALF + 8) @(negedge clk);
    check("glitch_idle_odd", busyOdd, 0);
    check("glitch_idle_even", busyEven, 0);
    send_frame(8'h3C, 1'b1, 1'b1, BIT);

    // Hand-built parity cases: each frame is wrong for exactly one receiver.
    send_frame(8'hA5, 1'b0, 1'b1, BIT);
    send_frame(8'h07, 1'b1, 1'b1, BIT);
    send_frame(8'h07, 1'b0, 1'b1, BIT);

    // Framing error: stop bit low, line held low two bit times, then recovery.
    send_frame(8'h81, 1'b1, 1'b0, BIT);
    drive_bit(1'b0, BIT);
    drive_bit(1'b1, BIT);
    send_frame(8'h42, 1'b0, 1'b1, BIT);
    wait_drain(4 * BIT);

    // Reset in the middle of data bit 3 discards the partial frame.
    partial = 8'hC3;
    drive_bit(1'b0, BIT);
    for (int i = 0; i < 3; i++) drive_bit(partial[i], BIT);
    drive_bit(partial[3], HALF);
    rst = 1'b1;
    @(negedge clk);
    check_cleared("midframe_reset");
    rst = 1'b0;
    drive_bit(1'b1, BIT + 4);
    send_frame(8'h99, 1'b1, 1'b1, BIT);

    // Random frames, transmitter period BIT or BIT+1, short random gaps.
    for (int n = 0; n < 24; n++) begin
      d = 8'($urandom);
      p = 1'($urandom);
      send_frame(d, p, 1'b1, BIT + int'($urandom_range(0, 1)));
      drive_bit(1'b1, int'($urandom_range(0, 3)));
    end
    wait_drain(4 * BIT);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
